// File: rtl/drap_pkg.sv
// Shared definitions for the fetch-stage program counter with return-address stack.
// Holds the per-cycle control priority encoding, the default parameter values,
// and the helper that maps the raw control strobes onto a single action.
package drap_pkg;

  // One action is taken per cycle, in this priority order.
  typedef enum logic [2:0] {
    CTL_HOLD = 3'd0,  // stall: PC, stack, count and flags all hold
    CTL_RET  = 3'd1,  // pop the RAS into the PC
    CTL_CALL = 3'd2,  // push the return address, jump to PC_in
    CTL_JMP  = 3'd3,  // absolute jump to PC_in
    CTL_BR   = 3'd4,  // PC-relative branch
    CTL_SEQ  = 3'd5   // sequential fetch
  } drap_ctl_e;

  localparam int unsigned DRAP_WIDTH_DEF     = 32;
  localparam int unsigned DRAP_INC_DEF       = 4;
  localparam int unsigned DRAP_RAS_DEPTH_DEF = 4;
  localparam logic [DRAP_WIDTH_DEF-1:0] DRAP_RESET_VEC_DEF = '0;

  function automatic drap_ctl_e drap_decode(input logic stall,
                                            input logic ret,
                                            input logic call,
                                            input logic load,
                                            input logic branch);
    drap_ctl_e ctl;
    if (stall)       ctl = CTL_HOLD;
    else if (ret)    ctl = CTL_RET;
    else if (call)   ctl = CTL_CALL;
    else if (load)   ctl = CTL_JMP;
    else if (branch) ctl = CTL_BR;
    else             ctl = CTL_SEQ;
    return ctl;
  endfunction

endpackage

// File: rtl/drap_ras.sv
// Return-address stack: circular LIFO of DEPTH x WIDTH entries.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, din     write din on top of the stack
//   pop, dout     dout is the current top entry (valid only when not empty)
//   empty, full   registered occupancy status
//   ovf, unf      sticky: push while full / pop while empty, cleared only by reset
// A push while full overwrites the oldest entry and leaves the count at DEPTH.
// A pop while empty changes nothing except setting unf.
// push and pop are expected to be mutually exclusive; push wins if both are set.
module drap_ras
  import drap_pkg::*;
#(
  parameter int unsigned WIDTH = DRAP_WIDTH_DEF,
  parameter int unsigned DEPTH = DRAP_RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // wp_q points at the slot the next push writes; the top entry sits just below it.
  // When full, wp_q therefore also points at the oldest entry, which makes the
  // overwrite-on-overflow behaviour fall out of the pointer arithmetic.
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] top_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  assign top_idx = wp_q - 1'b1;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      wp_d = wp_q + 1'b1;
      if (cnt_q == CNT_FULL) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        wp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  assign dout  = mem_q[top_idx];
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/drap_pc_ras.sv
// Fetch-stage program counter with reset vector, auto-increment, relative branch,
// absolute jump, stall, and call/return through a return-address stack.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   PC_stall            hold everything; other controls ignored
//   PC_load, PC_in      absolute jump to PC_in
//   PC_branch, PC_offset  relative branch by signed PC_offset
//   PC_call             push PC_out+INC, jump to PC_in
//   PC_ret              pop into PC (PC_out+INC if the stack is empty)
//   PC_out              registered current PC
//   RAS_empty/RAS_full  stack occupancy
//   RAS_ovf/RAS_unf     sticky overflow/underflow flags
module drap_pc_ras
  import drap_pkg::*;
#(
  parameter int unsigned     WIDTH     = DRAP_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DRAP_RESET_VEC_DEF),
  parameter int unsigned     INC       = DRAP_INC_DEF,
  parameter int unsigned     RAS_DEPTH = DRAP_RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_stall,
  input  logic             PC_load,
  input  logic [WIDTH-1:0] PC_in,
  input  logic             PC_branch,
  input  logic [WIDTH-1:0] PC_offset,
  input  logic             PC_call,
  input  logic             PC_ret,
  output logic [WIDTH-1:0] PC_out,
  output logic             RAS_empty,
  output logic             RAS_full,
  output logic             RAS_ovf,
  output logic             RAS_unf
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  drap_ctl_e        ctl;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] ras_dout;
  logic             ras_push, ras_pop, ras_empty;

  assign ctl      = drap_decode(PC_stall, PC_ret, PC_call, PC_load, PC_branch);
  assign pc_seq   = pc_q + INC_W;
  assign ras_push = (ctl == CTL_CALL);
  assign ras_pop  = (ctl == CTL_RET);

  drap_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_seq),
    .dout  (ras_dout),
    .empty (ras_empty),
    .full  (RAS_full),
    .ovf   (RAS_ovf),
    .unf   (RAS_unf)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (ctl)
      CTL_HOLD: pc_d = pc_q;
      // An empty stack never supplies a target; fall through to sequential fetch.
      CTL_RET:  pc_d = ras_empty ? pc_seq : ras_dout;
      CTL_CALL: pc_d = PC_in;
      CTL_JMP:  pc_d = PC_in;
      CTL_BR:   pc_d = pc_q + PC_offset;  // two's-complement add wraps modulo 2^WIDTH
      CTL_SEQ:  pc_d = pc_seq;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  assign PC_out    = pc_q;
  assign RAS_empty = ras_empty;

endmodule

// File: tb/tb_drap_pc_ras.sv
// Directed bench for drap_pc_ras (WIDTH=32, INC=4, RESET_VEC=0, RAS_DEPTH=4).
module tb_drap_pc_ras;

  logic        clk;
  logic        rst_n;
  logic        PC_stall, PC_load, PC_branch, PC_call, PC_ret;
  logic [31:0] PC_in, PC_offset;
  logic [31:0] PC_out;
  logic        RAS_empty, RAS_full, RAS_ovf, RAS_unf;

  int n_cmp = 0;
  int n_err = 0;

  drap_pc_ras #(
    .WIDTH     (32),
    .RESET_VEC (32'h0),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PC_stall  (PC_stall),
    .PC_load   (PC_load),
    .PC_in     (PC_in),
    .PC_branch (PC_branch),
    .PC_offset (PC_offset),
    .PC_call   (PC_call),
    .PC_ret    (PC_ret),
    .PC_out    (PC_out),
    .RAS_empty (RAS_empty),
    .RAS_full  (RAS_full),
    .RAS_ovf   (RAS_ovf),
    .RAS_unf   (RAS_unf)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one set of controls across a rising edge, then return them to idle.
  // Outputs are observed 10 time units after the edge.
  task automatic cyc(input logic st, input logic ld, input logic br,
                     input logic ca, input logic rt,
                     input logic [31:0] pin, input logic [31:0] poff);
    PC_stall  = st;
    PC_load   = ld;
    PC_branch = br;
    PC_call   = ca;
    PC_ret    = rt;
    PC_in     = pin;
    PC_offset = poff;
    @(posedge clk);
    #10;
    PC_stall  = 1'b0;
    PC_load   = 1'b0;
    PC_branch = 1'b0;
    PC_call   = 1'b0;
    PC_ret    = 1'b0;
  endtask

  task automatic flags(input string tag, input logic e, input logic f,
                       input logic o, input logic u);
    chk({tag, ".empty"}, {31'b0, RAS_empty}, {31'b0, e});
    chk({tag, ".full"},  {31'b0, RAS_full},  {31'b0, f});
    chk({tag, ".ovf"},   {31'b0, RAS_ovf},   {31'b0, o});
    chk({tag, ".unf"},   {31'b0, RAS_unf},   {31'b0, u});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] call_tgt [5];
    logic [31:0] ret_exp  [4];
    call_tgt = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    ret_exp  = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};

    rst_n = 1'b0;
    PC_stall = 0; PC_load = 0; PC_branch = 0; PC_call = 0; PC_ret = 0;
    PC_in = '0; PC_offset = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: reset state and sequential fetch
    chk("rst.pc", PC_out, 32'h0);
    flags("rst", 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq1", PC_out, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq2", PC_out, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("seq3", PC_out, 32'hC);
    chk("seq.empty", {31'b0, RAS_empty}, 32'h1);

    // 2: jump to the top of the address space, then wrap
    cyc(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0); chk("jmp", PC_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);             chk("wrap", PC_out, 32'h0);

    // 3: negative branch, first blocked by stall; load beats branch
    cyc(0, 1, 1, 0, 0, 32'h100, 32'h40);        chk("ld>br", PC_out, 32'h100);
    cyc(1, 0, 1, 0, 0, 0, 32'hFFFF_FFF0);       chk("br.stall", PC_out, 32'h100);
    cyc(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0);       chk("br.neg", PC_out, 32'hF0);

    // 4: call / return pair
    cyc(0, 1, 0, 0, 0, 32'h40, 0);  chk("to40", PC_out, 32'h40);
    cyc(0, 0, 0, 1, 0, 32'h800, 0); chk("call", PC_out, 32'h800);
    chk("call.empty", {31'b0, RAS_empty}, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("ret", PC_out, 32'h44);
    chk("ret.empty", {31'b0, RAS_empty}, 32'h1);

    // 5: overflow and underflow
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0, call_tgt[i], 0);
      chk($sformatf("call%0d", i), PC_out, call_tgt[i]);
      chk($sformatf("call%0d.full", i), {31'b0, RAS_full}, {31'b0, (i >= 3)});
      chk($sformatf("call%0d.ovf", i),  {31'b0, RAS_ovf},  {31'b0, (i == 4)});
    end
    cyc(1, 0, 0, 1, 1, 32'h9999, 0); chk("stall.ret", PC_out, 32'h5000);
    flags("stall.ret", 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk($sformatf("ret%0d", i), PC_out, ret_exp[i]);
    end
    flags("drained", 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("ret.unf", PC_out, 32'h1008);
    flags("unf", 1, 0, 1, 1);

    // ret and call together: ret wins, no push
    cyc(0, 0, 0, 1, 0, 32'h6000, 0); chk("call6", PC_out, 32'h6000);
    cyc(0, 0, 0, 1, 1, 32'h7000, 0); chk("ret+call", PC_out, 32'h100C);
    chk("ret+call.empty", {31'b0, RAS_empty}, 32'h1);

    // 6: asynchronous reset with two entries stacked
    cyc(0, 0, 0, 1, 0, 32'h8000, 0);
    cyc(0, 0, 0, 1, 0, 32'h9000, 0); chk("pre.rst", PC_out, 32'h9000);
    #20;
    rst_n = 1'b0;
    #1;
    chk("arst.pc", PC_out, 32'h0);
    flags("arst", 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0); chk("post.seq", PC_out, 32'h4);
    cyc(0, 0, 0, 0, 1, 0, 0); chk("post.ret", PC_out, 32'h8);
    flags("post", 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
